stim_check_seq: RTL and testbench
=================================

Name: stim_check_seq

Overview:
Self-checking stimulus sequencer that drives the unit under test and consumes its responses. It is the stage directly upstream and downstream of the assignment DUT in the bench. It issues NUM_VEC data words over a valid/ready handshake and compares each returned word in order against what was sent, since the DUT is a loopback. It summarises the run as done/pass/error count, so a bench top only pulses start and waits for done before printing its completion message.

Parameters:
DATA_W, 8, width of stimulus and response words (2..32).
NUM_VEC, 16, number of vectors per run (1..255).
SEED, 8'hA5, value of the first stimulus word; zero-extended or truncated to DATA_W.
MAX_OUT, 4, maximum outstanding (sent, not yet answered) words; depth of the expected-value FIFO; power of two, 2..16.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a run when idle
stim_valid  out  1  stimulus word valid
stim_ready  in  1  DUT accepts stimulus
stim_data  out  DATA_W  stimulus word
rsp_valid  in  1  DUT response valid; no backpressure, always consumed
rsp_data  in  DATA_W  DUT response word
busy  out  1  run in progress
done  out  1  high from run end until next start
pass  out  1  valid while done: 1 if err_count==0
err_count  out  8  mismatches this run, saturating at 255
vec_count  out  8  vectors sent this run

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low. On reset, all outputs are 0, the FSM goes to IDLE and the FIFO is empty.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when vec_count reaches NUM_VEC on a handshake.
  - DRAIN -> DONE when the outstanding count reaches 0.
  - DONE -> RUN on start. This clears the counters and re-seeds.
- start is ignored in RUN and DRAIN.
- busy = (RUN or DRAIN).
- done is a register, high in DONE only.
- pass is a register; it equals (err_count==0) while in DONE, and 0 otherwise.
- Stimulus generation:
  - Word k (k = 0..NUM_VEC-1) = SEED + k, modulo 2^DATA_W.
  - stim_valid is high in RUN while outstanding < MAX_OUT.
  - Once stim_valid is asserted, stim_data holds stable until the handshake, and stim_valid is not dropped before it.
  - A handshake (stim_valid & stim_ready) pushes stim_data into the expected FIFO, increments vec_count and advances k.
  - The first stim_valid rises on the cycle after start is sampled.
- Response check:
  - rsp_valid pops the FIFO head and compares it with rsp_data in the same cycle.
  - On a mismatch, err_count increments, saturating at 255.
  - rsp_valid with an empty FIFO is a spurious response: err_count increments and nothing is popped.
- Outstanding count:
  - A simultaneous push and pop leaves the outstanding count unchanged.
  - A push while full is impossible by construction, because stim_valid is gated.
- FIFO: pointers are log2(MAX_OUT)+1 bits and wrap naturally.
- Latency:
  - A zero-latency DUT is supported: the response may arrive in the cycle after its handshake.
  - A response in the same cycle as its own handshake is not supported.
- Reset mid-run: returns immediately to the reset state. No partial results are kept.

Optional Feature:
Macro: STIM_CHECK_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in RUN or DRAIN while outstanding > 0 and no rsp_valid arrives.
  - It clears on any rsp_valid or when outstanding == 0.
  - On reaching 1024 it forces DONE, adds the outstanding count to err_count (saturating) and empties the FIFO.
  - pass is therefore 0.
- When undefined: no watchdog logic; a dead DUT hangs in DRAIN with busy high.

Test Plan:
- Loopback, ideal: defaults, stim_ready=1, DUT echoes each word 1 cycle later.
  - stim_data sequence A5, A6, ... B4.
  - done after the 16th response; pass=1, err_count=0, vec_count=16.
- Backpressure: stim_ready toggled pseudo-randomly and DUT latency held at 6 cycles.
  - stim_valid never exceeds 4 outstanding; data stays stable while stalled.
  - pass=1.
- Corruption: DUT flips bit 0 on responses 3 and 10.
  - err_count=2, pass=0, done=1.
- Spurious and wrap: SEED=8'hFE, NUM_VEC=4, extra rsp_valid injected while the FIFO is empty.
  - Words FE, FF, 00, 01.
  - err_count=1.
- Reset mid-run: assert rst_n=0 after 5 handshakes, release, pulse start.
  - All outputs 0 during reset; the new run restarts at A5 and completes with pass=1.
- Timeout (macro defined): DUT never responds.
  - done 1024 cycles after the 4th handshake; err_count=4, pass=0.

Source files
------------

// File: rtl/stim_check_seq.sv
// stim_check_seq: stimulus sequencer with in-order loopback response checker.
// Optional response watchdog is enabled by defining STIM_CHECK_TIMEOUT_EN.
module stim_check_seq #(
    parameter int          DATA_W  = 8,
    parameter int          NUM_VEC = 16,
    parameter logic [31:0] SEED    = 32'hA5,
    parameter int          MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              stim_valid,
    input  logic              stim_ready,
    output logic [DATA_W-1:0] stim_data,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [7:0]        vec_count
);

    localparam int AW = $clog2(MAX_OUT);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]     FULL   = PW'(MAX_OUT);
    localparam logic [7:0]        LAST   = 8'(NUM_VEC - 1);
    localparam logic [DATA_W-1:0] SEED_W = SEED[DATA_W-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] fifo [MAX_OUT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     occ;
    logic              hs;
    logic              pop;
    logic              spur;
    logic              mism;
    logic              restart;
    logic              timeout;
    logic [8:0]        err_sum;
    logic [7:0]        err_next;

    assign occ        = wr_ptr - rd_ptr;
    assign stim_valid = (state == RUN) && (occ < FULL);
    assign hs         = stim_valid && stim_ready;
    assign pop        = rsp_valid && (state != IDLE) && (occ != '0);
    assign spur       = rsp_valid && (state != IDLE) && (occ == '0);
    assign mism       = pop && (fifo[rd_ptr[AW-1:0]] != rsp_data);
    assign restart    = start && ((state == IDLE) || (state == DONE));

`ifdef STIM_CHECK_TIMEOUT_EN
    logic [15:0] wd;
    logic        active;

    assign active  = (state == RUN) || (state == DRAIN);
    assign timeout = active && (occ != '0) && !rsp_valid && (wd == 16'd1023);

    // Watchdog: counts cycles with words outstanding and no response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (!active || (occ == '0) || rsp_valid || timeout) begin
            wd <= '0;
        end else begin
            wd <= wd + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next error count; a timeout charges every unanswered word
    always_comb begin
        err_sum = {1'b0, err_count} + {8'd0, (mism | spur)};
        if (timeout) begin
            err_sum = err_sum + 9'(occ) + {8'd0, hs};
        end
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Run-state transitions
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                if (timeout) begin
                    state_nx = DONE;
                end else if (hs && (vec_count == LAST)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: if (timeout || (occ == '0)) state_nx = DONE;
            DONE:  if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer state, counters, pointers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim_data <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vec_count <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN) || (state_nx == DRAIN);
            done  <= (state_nx == DONE);
            pass  <= (state_nx == DONE) && (err_next == 8'd0);
            if (restart) begin
                stim_data <= SEED_W;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                vec_count <= '0;
                err_count <= '0;
            end else begin
                err_count <= err_next;
                if (hs) begin
                    stim_data <= stim_data + DATA_W'(1);
                    wr_ptr    <= wr_ptr + PW'(1);
                    vec_count <= vec_count + 8'd1;
                end
                if (timeout) begin
                    rd_ptr <= wr_ptr + PW'(hs);
                end else if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Expected-word store, written on every accepted stimulus word
    always_ff @(posedge clk) begin
        if (hs) begin
            fifo[wr_ptr[AW-1:0]] <= stim_data;
        end
    end

endmodule

// File: tb/tb_stim_check_seq.sv
// tb_stim_check_seq: directed bench for stim_check_seq with a loopback
// responder model and an expected-word scoreboard queue.
module tb_stim_check_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic       stim_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    logic       a_valid, a_busy, a_done, a_pass;
    logic [7:0] a_data, a_err, a_vec;
    logic       b_valid, b_busy, b_done, b_pass;
    logic [7:0] b_data, b_err, b_vec;

    stim_check_seq u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .stim_valid(a_valid), .stim_ready(stim_ready), .stim_data(a_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .vec_count(a_vec)
    );

    stim_check_seq #(.SEED(32'hFE), .NUM_VEC(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .stim_valid(b_valid), .stim_ready(stim_ready), .stim_data(b_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .vec_count(b_vec)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
    } rsp_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         sel = 1'b0;
    int         nv = 16;
    logic [7:0] seed = 8'hA5;
    int         lat = 1;
    bit         rnd_ready = 1'b0;
    bit         hold_ready = 1'b0;
    bit         dead = 1'b0;
    bit         inject = 1'b0;
    bit         running = 1'b0;
    int         bad0 = -1;
    int         bad1 = -1;
    int         sent = 0;
    int         got = 0;
    int         exp_err = 0;
    int         hs4_cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] stall_d = 8'h00;
    logic [7:0] exp_q[$];
    rsp_t       pipe[$];

    logic       o_valid, o_busy, o_done, o_pass;
    logic [7:0] o_data, o_err, o_vec;

    always_comb begin
        o_valid = sel ? b_valid : a_valid;
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_pass  = sel ? b_pass  : a_pass;
        o_data  = sel ? b_data  : a_data;
        o_err   = sel ? b_err   : a_err;
        o_vec   = sel ? b_vec   : a_vec;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs, drive inputs for the next rising edge
    task automatic tick();
        int out;
        logic [7:0] e;
        out = sent - got;
        if (running) begin
            if (stalled) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, stall_d);
            end
            chk("stim_valid", o_valid, (sent < nv) && (out < 4));
        end
        if (hold_ready) stim_ready = 1'b0;
        else if (rnd_ready) stim_ready = 1'($urandom_range(0, 1));
        else stim_ready = 1'b1;
        stalled = 1'b0;
        if (running && o_valid) begin
            if (stim_ready) begin
                chk("stim_data", o_data, 8'(seed + sent));
                exp_q.push_back(8'(seed + sent));
                if (!dead) begin
                    pipe.push_back('{cyc + lat, o_data ^
                        (((sent == bad0) || (sent == bad1)) ? 8'h01 : 8'h00)});
                end
                sent++;
                if (sent == 4) hs4_cyc = cyc;
            end else begin
                stalled = 1'b1;
                stall_d = o_data;
            end
        end
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        if ((pipe.size() > 0) && (pipe[0].due == cyc)) begin
            rsp_valid = 1'b1;
            rsp_data  = pipe[0].d;
            void'(pipe.pop_front());
        end else if (inject) begin
            rsp_valid = 1'b1;
            rsp_data  = 8'h5A;
            inject    = 1'b0;
        end
        if (rsp_valid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got++;
                if (e !== rsp_data) exp_err++;
            end else begin
                exp_err++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input bit s, input int l, input bit rr,
                       input int b0, input int b1, input bit dd,
                       input int hold, input int abort_at,
                       input int want_err, input int want_vec);
        sel = s;
        nv = s ? 4 : 16;
        seed = s ? 8'hFE : 8'hA5;
        lat = l;
        rnd_ready = rr;
        bad0 = b0;
        bad1 = b1;
        dead = dd;
        sent = 0;
        got = 0;
        exp_err = 0;
        stalled = 1'b0;
        exp_q.delete();
        pipe.delete();
        if (s) start_b = 1'b1;
        else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        running = 1'b1;
        if (hold > 0) begin
            hold_ready = 1'b1;
            inject = 1'b1;
            for (int i = 0; i < hold; i++) tick();
            hold_ready = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            if ((abort_at > 0) && (sent >= abort_at)) break;
            if (o_done) break;
            tick();
        end
        if (abort_at > 0) begin
            chk("abort_reached", sent, abort_at);
            running = 1'b0;
            return;
        end
        running = 1'b0;
        chk("done", o_done, 1);
        if (o_done) begin
            chk("err_count", o_err, want_err);
            chk("err_model", o_err, exp_err);
            chk("pass", o_pass, (want_err == 0));
            chk("vec_count", o_vec, want_vec);
            chk("busy_end", o_busy, 0);
            chk("valid_end", o_valid, 0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_data"}, a_data, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_pass"}, a_pass, 0);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_vec"}, a_vec, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        stim_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ideal loopback, one-cycle echo
        run(0, 1, 0, -1, -1, 0, 0, 0, 0, 16);
        // random backpressure, six-cycle responder
        run(0, 6, 1, -1, -1, 0, 0, 0, 0, 16);
        // bit 0 flipped on two responses
        run(0, 1, 0, 3, 10, 0, 0, 0, 2, 16);

        // reset after five handshakes, then a clean run
        run(0, 1, 0, -1, -1, 0, 0, 5, 0, 0);
        rst_n = 1'b0;
        stim_ready = 1'b0;
        rsp_valid = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge clk);
        chk_reset("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1, 0, -1, -1, 0, 0, 0, 0, 16);

        // wrapping seed with a spurious response while empty
        run(1, 1, 0, -1, -1, 0, 2, 0, 1, 4);

`ifdef STIM_CHECK_TIMEOUT_EN
        // responder never answers
        run(0, 1, 0, -1, -1, 1, 0, 0, 4, 4);
        chk("timeout_lat", ((cyc - hs4_cyc) >= 1015) &&
                           ((cyc - hs4_cyc) <= 1030), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
